// File: rtl/gaussian_filter_3x3_if.sv
// Window-in / filtered-pixel-out bundle for the 3x3 Gaussian filter.
// The master side owns the window and syncs; the slave side is the filter.
interface gaussian_filter_3x3_if;
    logic       matrix_de;
    logic       matrix_vs;
    logic       matrix_hs;
    logic [7:0] matrix11;
    logic [7:0] matrix12;
    logic [7:0] matrix13;
    logic [7:0] matrix21;
    logic [7:0] matrix22;
    logic [7:0] matrix23;
    logic [7:0] matrix31;
    logic [7:0] matrix32;
    logic [7:0] matrix33;
    logic       post_de;
    logic       post_vs;
    logic       post_hs;
    logic [7:0] post_data;

    modport master (
        output matrix_de, matrix_vs, matrix_hs,
        output matrix11, matrix12, matrix13,
        output matrix21, matrix22, matrix23,
        output matrix31, matrix32, matrix33,
        input  post_de, post_vs, post_hs, post_data
    );

    modport slave (
        input  matrix_de, matrix_vs, matrix_hs,
        input  matrix11, matrix12, matrix13,
        input  matrix21, matrix22, matrix23,
        input  matrix31, matrix32, matrix33,
        output post_de, post_vs, post_hs, post_data
    );
endinterface

// File: rtl/gaussian_filter_3x3.sv
// 3x3 Gaussian smoothing ([1 2 1; 2 4 2; 1 2 1] / 16) over a pre-built window.
// Three-stage pipeline; frame-border pixels pass the centre pixel through unfiltered.
module gaussian_filter_3x3 #(
    parameter logic [10:0] IMG_WIDTH  = 11'd1920,
    parameter logic [10:0] IMG_HEIGHT = 11'd1080
) (
    input  logic                        video_clk,
    input  logic                        rst_n,
    gaussian_filter_3x3_if.slave        vid
);
    localparam logic [11:0] X_LAST = {1'b0, IMG_WIDTH} - 12'd1;
    localparam logic [11:0] Y_LAST = {1'b0, IMG_HEIGHT} - 12'd1;

    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic [9:0]  row1;
    logic [9:0]  row2;
    logic [9:0]  row3;
    logic [11:0] total;
    logic [11:0] rounded;
    logic [7:0]  center1;
    logic [7:0]  center2;
    logic        border1;
    logic        border2;
    logic [1:0]  de_d;
    logic [1:0]  vs_d;
    logic [1:0]  hs_d;
    logic        border_now;
    logic        de_fall;
    logic        vs_rise;

    function automatic logic [9:0] row_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Stage-1 sync registers double as the edge detectors for de and vs.
    always_comb begin
        border_now = (x_cnt == 12'd0) || (x_cnt == X_LAST) ||
                     (y_cnt == 12'd0) || (y_cnt == Y_LAST);
        de_fall    = de_d[0] & ~vid.matrix_de;
        vs_rise    = vid.matrix_vs & ~vs_d[0];
        rounded    = total + 12'd8;
    end

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vs_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (de_fall) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt >= Y_LAST) ? 12'd0 : y_cnt + 12'd1;
        end else if (vid.matrix_de && (x_cnt < X_LAST)) begin
            x_cnt <= x_cnt + 12'd1;
        end
    end

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            row1          <= '0;
            row2          <= '0;
            row3          <= '0;
            total         <= '0;
            center1       <= '0;
            center2       <= '0;
            border1       <= 1'b0;
            border2       <= 1'b0;
            de_d          <= '0;
            vs_d          <= '0;
            hs_d          <= '0;
            vid.post_de   <= 1'b0;
            vid.post_vs   <= 1'b0;
            vid.post_hs   <= 1'b0;
            vid.post_data <= '0;
        end else begin
            row1    <= row_sum(vid.matrix11, vid.matrix12, vid.matrix13);
            row2    <= row_sum(vid.matrix21, vid.matrix22, vid.matrix23);
            row3    <= row_sum(vid.matrix31, vid.matrix32, vid.matrix33);
            center1 <= vid.matrix22;
            border1 <= border_now;

            total   <= {2'b00, row1} + {1'b0, row2, 1'b0} + {2'b00, row3};
            center2 <= center1;
            border2 <= border1;

            de_d <= {de_d[0], vid.matrix_de};
            vs_d <= {vs_d[0], vid.matrix_vs};
            hs_d <= {hs_d[0], vid.matrix_hs};

            vid.post_de <= de_d[1];
            vid.post_vs <= vs_d[1];
            vid.post_hs <= hs_d[1];
            if (!de_d[1])
                vid.post_data <= 8'd0;
            else if (border2)
                vid.post_data <= center2;
            else
                vid.post_data <= rounded[11:4];
        end
    end
endmodule
